// File: rtl/barrido_tabla_pkg.sv
// Shared definitions for the truth-table sweep checker: row width,
// shared delay counter width and FSM state encoding.
package barrido_tabla_pkg;

  localparam int unsigned FILA_W = 3;
  localparam int unsigned CNT_W  = 24;
  localparam int unsigned MISM_W = 4;

  localparam logic [FILA_W-1:0] FILA_ULT = '1;
  localparam logic [MISM_W-1:0] MISM_MAX = 4'd8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    WAIT   = 3'd4,
    DONE   = 3'd5
  } estado_t;

endpackage

// File: rtl/barrido_tabla_detector.sv
// Two-flop synchronizer followed by a rising-edge detector; a held
// input yields exactly one registered single-cycle pulse.
module detector_flanco (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulso
);

  logic r_s1;
  logic r_s2;
  logic r_prev;
  logic r_pulso;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_prev  <= 1'b0;
      r_pulso <= 1'b0;
    end else begin
      r_s1    <= in;
      r_s2    <= r_s1;
      r_prev  <= r_s2;
      r_pulso <= r_s2 & ~r_prev;
    end
  end

  assign pulso = r_pulso;

endmodule

// File: rtl/barrido_tabla.sv
// Sweeps all eight rows of a 3-input truth table, comparing a reference
// output against the implementation under check; manual or timed stepping.
module barrido_tabla
  import barrido_tabla_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned DIV        = 12_500_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inicio,
  input  logic              modo,
  input  logic              paso,
  input  logic              Y_ref,
  input  logic              Y_dut,
  output logic              A,
  output logic              B,
  output logic              C,
  output logic [FILA_W-1:0] fila,
  output logic              error,
  output logic [FILA_W-1:0] err_fila,
  output logic [MISM_W-1:0] mism,
  output logic              listo,
  output logic              pasa
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DIV_LD    = CNT_W'(DIV - 1);

  estado_t             r_estado;
  logic [CNT_W-1:0]    r_cnt;
  logic [FILA_W-1:0]   r_fila;
  logic [FILA_W-1:0]   r_abc;
  logic                r_error;
  logic [FILA_W-1:0]   r_err_fila;
  logic [MISM_W-1:0]   r_mism;
  logic                r_listo;
  logic                r_pasa;
  logic                w_paso_pulso;

  detector_flanco u_det_paso (
    .clk   (clk),
    .reset (reset),
    .in    (paso),
    .pulso (w_paso_pulso)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado   <= IDLE;
      r_cnt      <= '0;
      r_fila     <= '0;
      r_abc      <= '0;
      r_error    <= 1'b0;
      r_err_fila <= '0;
      r_mism     <= '0;
      r_listo    <= 1'b0;
      r_pasa     <= 1'b0;
    end else if (inicio) begin
      r_estado   <= APPLY;
      r_cnt      <= '0;
      r_fila     <= '0;
      r_error    <= 1'b0;
      r_err_fila <= '0;
      r_mism     <= '0;
      r_listo    <= 1'b0;
      r_pasa     <= 1'b0;
    end else begin
      case (r_estado)
        IDLE: ;
        APPLY: begin
          r_abc    <= r_fila;
          r_cnt    <= SETTLE_LD;
          r_estado <= SETTLE;
        end
        SETTLE: begin
          if (r_cnt == '0) r_estado <= SAMPLE;
          else             r_cnt    <= r_cnt - 1'b1;
        end
        SAMPLE: begin
          if (Y_ref != Y_dut) begin
            if (r_mism != MISM_MAX) r_mism <= r_mism + 1'b1;
            if (!r_error) r_err_fila <= r_fila;
            r_error <= 1'b1;
          end
          if (r_fila == FILA_ULT) begin
            r_estado <= DONE;
          end else begin
            r_cnt    <= DIV_LD;
            r_estado <= WAIT;
          end
        end
        WAIT: begin
          // Manual mode keeps the counter primed so a switch to auto waits a full DIV.
          if (modo) begin
            if (r_cnt == '0) begin
              r_fila   <= r_fila + 1'b1;
              r_estado <= APPLY;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end else begin
            r_cnt <= DIV_LD;
            if (w_paso_pulso) begin
              r_fila   <= r_fila + 1'b1;
              r_estado <= APPLY;
            end
          end
        end
        DONE: begin
          r_listo <= 1'b1;
          r_pasa  <= ~r_error;
        end
        default: r_estado <= IDLE;
      endcase
    end
  end

  assign A        = r_abc[2];
  assign B        = r_abc[1];
  assign C        = r_abc[0];
  assign fila     = r_fila;
  assign error    = r_error;
  assign err_fila = r_err_fila;
  assign mism     = r_mism;
  assign listo    = r_listo;
  assign pasa     = r_pasa;

endmodule

// File: tb/tb_barrido_tabla.sv
// Self-checking bench for barrido_tabla: timed sweeps against an
// arithmetic timeline model, manual stepping, restart and reset cases.
module tb_barrido_tabla;

  localparam int unsigned DIV_T    = 4;
  localparam int unsigned SETTLE_T = 2;
  localparam int unsigned PER      = 2 + SETTLE_T + DIV_T;
  localparam int unsigned LAT      = 7 * PER + (2 + SETTLE_T) + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       inicio = 1'b0;
  logic       modo = 1'b1;
  logic       paso = 1'b0;
  logic       y_ref;
  logic       y_dut;
  logic       A, B, C;
  logic [2:0] fila;
  logic       error;
  logic [2:0] err_fila;
  logic [3:0] mism;
  logic       listo;
  logic       pasa;

  logic [7:0] tabla = 8'h96;
  logic [7:0] mascara = 8'h00;
  logic       forzar_rnd = 1'b0;
  logic       rnd_ref = 1'b0;
  logic       rnd_dut = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    y_ref = tabla[{A, B, C}];
    y_dut = y_ref ^ mascara[{A, B, C}];
    if (forzar_rnd) begin
      y_ref = rnd_ref;
      y_dut = rnd_dut;
    end
  end

  barrido_tabla #(.SETTLE_CYC(SETTLE_T), .DIV(DIV_T)) dut (
    .clk      (clk),
    .reset    (reset),
    .inicio   (inicio),
    .modo     (modo),
    .paso     (paso),
    .Y_ref    (y_ref),
    .Y_dut    (y_dut),
    .A        (A),
    .B        (B),
    .C        (C),
    .fila     (fila),
    .error    (error),
    .err_fila (err_fila),
    .mism     (mism),
    .listo    (listo),
    .pasa     (pasa)
  );

  function automatic int unsigned cuenta_bits(input logic [7:0] m);
    int unsigned n = 0;
    for (int i = 0; i < 8; i++) if (m[i]) n++;
    return (n > 8) ? 8 : n;
  endfunction

  function automatic logic [2:0] primera_fila(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return 3'(i);
    return 3'd0;
  endfunction

  function automatic int unsigned min7(input int unsigned v);
    return (v > 7) ? 7 : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after the edge that sampled inicio.
  task automatic pulsar_inicio();
    @(negedge clk);
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
  endtask

  task automatic todo_cero(input string nombre);
    logic [15:0] obs;
    obs = {A, B, C, fila, error, err_fila, mism, listo, pasa};
    checks++;
    if (obs !== 16'h0) begin
      failures++;
      $display("FAIL %s: outputs={ABC,fila,err,err_fila,mism,listo,pasa}=%h expected 0000", nombre, obs);
    end
  endtask

  task automatic run_auto(input logic [7:0] m, input string nombre);
    int unsigned malos = 0;
    int unsigned k_malo = 0;
    logic [2:0] exp_abc;
    logic [2:0] exp_fila;
    logic       exp_listo;
    mascara = m;
    modo = 1'b1;
    pulsar_inicio();
    checks++;
    if (fila !== 3'd0 || error !== 1'b0 || mism !== 4'd0 || err_fila !== 3'd0 || listo !== 1'b0) begin
      failures++;
      $display("FAIL %s_start: fila=%0d error=%0b mism=%0d err_fila=%0d listo=%0b expected all 0",
               nombre, fila, error, mism, err_fila, listo);
    end
    for (int unsigned k = 1; k <= LAT; k++) begin
      tick();
      exp_abc   = 3'(min7((k - 1) / PER));
      exp_fila  = 3'(min7(k / PER));
      exp_listo = (k >= LAT);
      if ({A, B, C} !== exp_abc || fila !== exp_fila || listo !== exp_listo) begin
        if (malos == 0) k_malo = k;
        malos++;
      end
    end
    checks++;
    if (malos != 0) begin
      failures++;
      $display("FAIL %s_trace: %0d bad cycles, first at cycle %0d (ABC=%0d fila=%0d listo=%0b)",
               nombre, malos, k_malo, {A, B, C}, fila, listo);
    end
    checks++;
    if (listo !== 1'b1) begin
      failures++;
      $display("FAIL %s_listo: listo=%0b at cycle %0d expected 1", nombre, listo, LAT);
    end
    checks++;
    if (error !== (m != 8'h00) || mism !== 4'(cuenta_bits(m)) || pasa !== (m == 8'h00)) begin
      failures++;
      $display("FAIL %s_result: error=%0b mism=%0d pasa=%0b expected error=%0b mism=%0d pasa=%0b",
               nombre, error, mism, pasa, (m != 8'h00), cuenta_bits(m), (m == 8'h00));
    end
    if (m != 8'h00) begin
      checks++;
      if (err_fila !== primera_fila(m)) begin
        failures++;
        $display("FAIL %s_err_fila: err_fila=%0d expected %0d", nombre, err_fila, primera_fila(m));
      end
    end
    repeat (3) tick();
    checks++;
    if (listo !== 1'b1 || pasa !== (m == 8'h00)) begin
      failures++;
      $display("FAIL %s_hold: listo=%0b pasa=%0b expected 1 %0b", nombre, listo, pasa, (m == 8'h00));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    forzar_rnd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      inicio  = 1'($urandom);
      modo    = 1'($urandom);
      paso    = 1'($urandom);
      rnd_ref = 1'($urandom);
      rnd_dut = 1'($urandom);
    end
    tick();
    todo_cero("reset_outputs");
    @(negedge clk);
    reset = 1'b0;
    inicio = 1'b0;
    paso = 1'b0;
    forzar_rnd = 1'b0;
    repeat (6) tick();
    todo_cero("reset_idle");
  endtask

  task automatic test_auto_random();
    run_auto(8'h00, "auto_clean");
    run_auto(8'h20, "auto_row5");
    run_auto(8'hFF, "auto_all");
    for (int i = 0; i < 4; i++) begin
      tabla = 8'($urandom);
      run_auto(8'($urandom), "auto_rand");
    end
  endtask

  task automatic test_manual();
    mascara = 8'h00;
    modo = 1'b0;
    paso = 1'b0;
    pulsar_inicio();
    repeat (50) tick();
    checks++;
    if (fila !== 3'd0) begin
      failures++;
      $display("FAIL manual_idle: fila=%0d expected 0", fila);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); paso = 1'b1;
      repeat (10) @(negedge clk);
      paso = 1'b0;
      repeat (10) @(negedge clk);
    end
    tick();
    checks++;
    if (fila !== 3'd3) begin
      failures++;
      $display("FAIL manual_three: fila=%0d expected 3", fila);
    end
    @(negedge clk); paso = 1'b1;
    repeat (40) @(negedge clk);
    paso = 1'b0;
    repeat (20) tick();
    checks++;
    if (fila !== 3'd4 || listo !== 1'b0) begin
      failures++;
      $display("FAIL manual_held: fila=%0d listo=%0b expected 4 0", fila, listo);
    end
  endtask

  task automatic test_restart();
    int unsigned n = 0;
    mascara = 8'h44;
    modo = 1'b1;
    pulsar_inicio();
    while (fila !== 3'd4 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (fila !== 3'd4 || error !== 1'b1 || mism !== 4'd1 || err_fila !== 3'd2) begin
      failures++;
      $display("FAIL restart_pre: fila=%0d error=%0b mism=%0d err_fila=%0d expected 4 1 1 2",
               fila, error, mism, err_fila);
    end
    run_auto(8'h40, "restart");
  endtask

  task automatic test_reset_mid();
    mascara = 8'($urandom);
    modo = 1'b1;
    pulsar_inicio();
    repeat (3 * PER + 1) tick();
    checks++;
    if (fila !== 3'd3 || {A, B, C} !== 3'd3) begin
      failures++;
      $display("FAIL midreset_pre: fila=%0d ABC=%0d expected 3 3", fila, {A, B, C});
    end
    reset = 1'b1;
    tick();
    todo_cero("midreset_outputs");
    reset = 1'b0;
    repeat (4) tick();
    todo_cero("midreset_idle");
    run_auto(8'($urandom), "after_reset");
  endtask

  initial begin
    test_reset();
    test_auto_random();
    test_manual();
    test_restart();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
